// File: rtl/rob_commit.sv
// Reorder buffer with two-wide allocation, two completion ports and
// two-wide in-order commit. A retired entry carrying a redirect flushes
// the whole buffer and pulses flush/flush_pc alongside its commit write.
//
// Allocation handshake: an allocation is accepted at a rising edge when
// alloc_valid_a && alloc_ready && !flush_pending. Slot B is only accepted
// together with slot A. alloc_loc_a/alloc_loc_b show the tags that the
// accepted entries receive, and they are valid in the same cycle.
module rob_commit #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_valid_a,
  input  logic        alloc_valid_b,
  input  logic [2:0]  alloc_dest_a,
  input  logic [2:0]  alloc_dest_b,
  input  logic        alloc_wen_a,
  input  logic        alloc_wen_b,
  output logic [5:0]  alloc_loc_a,
  output logic [5:0]  alloc_loc_b,
  output logic        alloc_ready,
  input  logic        cmpl_valid0,
  input  logic        cmpl_valid1,
  input  logic [5:0]  cmpl_loc0,
  input  logic [5:0]  cmpl_loc1,
  input  logic [15:0] cmpl_data0,
  input  logic [15:0] cmpl_data1,
  input  logic        cmpl_redirect0,
  input  logic        cmpl_redirect1,
  input  logic [15:0] cmpl_target0,
  input  logic [15:0] cmpl_target1,
  output logic        wen0,
  output logic        wen1,
  output logic [2:0]  waddr0,
  output logic [2:0]  waddr1,
  output logic [15:0] wdata0,
  output logic [15:0] wdata1,
  output logic [5:0]  wrob0,
  output logic [5:0]  wrob1,
  output logic        flush,
  output logic [15:0] flush_pc,
  output logic [6:0]  count
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [2:0]       dest_q  [DEPTH];
  logic             wen_q   [DEPTH];
  logic [15:0]      data_q  [DEPTH];
  logic             redir_q [DEPTH];
  logic [15:0]      tgt_q   [DEPTH];

  logic [5:0] head, tail, head1, new_head;
  logic       ret0, ret1, flush_pending;
  logic [1:0] n_ret, n_alloc;
  logic       acc_a, acc_b;

  assign alloc_loc_a = tail;
  assign alloc_loc_b = tail + 6'd1;
  assign alloc_ready = (count <= 7'd62);

  // Retire and accept decisions, all taken from pre-edge state.
  always_comb begin
    head1         = head + 6'd1;
    ret0          = valid_q[head] & done_q[head];
    ret1          = ret0 & ~redir_q[head] & valid_q[head1] & done_q[head1];
    flush_pending = (ret0 & redir_q[head]) | (ret1 & redir_q[head1]);
    n_ret         = {1'b0, ret0} + {1'b0, ret1};
    new_head      = head + {4'd0, n_ret};
    acc_a         = alloc_valid_a & alloc_ready & ~flush_pending;
    acc_b         = acc_a & alloc_valid_b;
    n_alloc       = {1'b0, acc_a} + {1'b0, acc_b};
  end

  // Pointers, occupancy and per-entry valid/done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush_pending) begin
      head    <= new_head;
      tail    <= new_head;
      count   <= '0;
      valid_q <= '0;
    end else begin
      head  <= new_head;
      tail  <= tail + {4'd0, n_alloc};
      count <= count + {5'd0, n_alloc} - {5'd0, n_ret};
      if (ret0) valid_q[head] <= 1'b0;
      if (ret1) valid_q[head1] <= 1'b0;
      if (cmpl_valid0 && valid_q[cmpl_loc0]) done_q[cmpl_loc0] <= 1'b1;
      if (cmpl_valid1 && valid_q[cmpl_loc1]) done_q[cmpl_loc1] <= 1'b1;
      if (acc_a) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
      end
      if (acc_b) begin
        valid_q[tail + 6'd1] <= 1'b1;
        done_q[tail + 6'd1]  <= 1'b0;
      end
    end
  end

  // Entry payload; port 1 is written last so it wins a same-tag collision.
  always_ff @(posedge clk) begin
    if (!flush_pending) begin
      if (acc_a) begin
        dest_q[tail]  <= alloc_dest_a;
        wen_q[tail]   <= alloc_wen_a;
        redir_q[tail] <= 1'b0;
      end
      if (acc_b) begin
        dest_q[tail + 6'd1]  <= alloc_dest_b;
        wen_q[tail + 6'd1]   <= alloc_wen_b;
        redir_q[tail + 6'd1] <= 1'b0;
      end
      if (cmpl_valid0 && valid_q[cmpl_loc0]) begin
        data_q[cmpl_loc0]  <= cmpl_data0;
        redir_q[cmpl_loc0] <= cmpl_redirect0;
        tgt_q[cmpl_loc0]   <= cmpl_target0;
      end
      if (cmpl_valid1 && valid_q[cmpl_loc1]) begin
        data_q[cmpl_loc1]  <= cmpl_data1;
        redir_q[cmpl_loc1] <= cmpl_redirect1;
        tgt_q[cmpl_loc1]   <= cmpl_target1;
      end
    end
  end

  // Registered commit writes and flush pulse, one cycle after retirement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen0     <= 1'b0;
      wen1     <= 1'b0;
      waddr0   <= '0;
      waddr1   <= '0;
      wdata0   <= '0;
      wdata1   <= '0;
      wrob0    <= '0;
      wrob1    <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      wen0     <= ret0 & wen_q[head];
      wen1     <= ret1 & wen_q[head1];
      waddr0   <= ret0 ? dest_q[head] : 3'd0;
      waddr1   <= ret1 ? dest_q[head1] : 3'd0;
      wdata0   <= ret0 ? data_q[head] : 16'd0;
      wdata1   <= ret1 ? data_q[head1] : 16'd0;
      wrob0    <= ret0 ? head : 6'd0;
      wrob1    <= ret1 ? head1 : 6'd0;
      flush    <= flush_pending;
      flush_pc <= !flush_pending ? 16'd0 :
                  (ret0 && redir_q[head]) ? tgt_q[head] : tgt_q[head1];
    end
  end

endmodule
